// File: rtl/fpu_add_sub_round_apply_pkg.sv
// fpu_add_sub_round_apply_pkg: shared FPU constants for rounding modes, round decisions, fflags and f32 encodings
package fpu_add_sub_round_apply_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [1:0] RND_NONE = 2'b00;
  localparam logic [1:0] RND_INC = 2'b01;
  localparam logic [1:0] RND_DEC = 2'b11;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  localparam logic [31:0] F32_PINF = 32'h7F80_0000;
  localparam logic [31:0] F32_MAX = 32'h7F7F_FFFF;
endpackage

// File: rtl/fpu_overflow_select.sv
// fpu_overflow_select: maps rounding mode and sign to the overflowed single-precision result
//   rm   in  3   resolved rounding mode
//   sign in  1   result sign
//   res  out 32  signed infinity or signed largest finite value
module fpu_overflow_select
  import fpu_add_sub_round_apply_pkg::*;
(
  input  logic [2:0]  rm,
  input  logic        sign,
  output logic [31:0] res
);
  logic to_max;
  // Saturate when rounding toward zero, or when the directed mode points back toward zero
  assign to_max = rm == RM_RTZ | (rm == RM_RDN & !sign) | (rm == RM_RUP & sign);
  assign res = {sign, to_max ? F32_MAX[30:0] : F32_PINF[30:0]};
endmodule

// File: rtl/fpu_add_sub_round_apply.sv
// fpu_add_sub_round_apply: applies the add/sub rounding step, renormalizes, resolves overflow and packs f32
//   clk_i, reset_i (sync, active low)
//   in_valid_i/in_ready_o, sign_i, exp_i, sig_i, lrs_i, round_i, rm_i, special_i, special_res_i, special_flags_i
//   out_valid_o/out_ready_i, result_o, fflags_o {NV,DZ,OF,UF,NX}
module fpu_add_sub_round_apply
  import fpu_add_sub_round_apply_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int SIG_W = 24
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [SIG_W-1:0] sig_i,
  input  logic [2:0]       lrs_i,
  input  logic [1:0]       round_i,
  input  logic [2:0]       rm_i,
  input  logic             special_i,
  input  logic [31:0]      special_res_i,
  input  logic [4:0]       special_flags_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      result_o,
  output logic [4:0]       fflags_o
);
  logic             s1_valid, s2_valid, s2_adv;
  logic             s1_sign, s1_msb, s1_nx, s1_special;
  logic [EXP_W-1:0] s1_exp, n_exp;
  logic [SIG_W:0]   s1_sig, addend;
  logic [SIG_W-1:0] n_sig;
  logic [2:0]       s1_rm;
  logic [31:0]      s1_special_res, ovf_res, res;
  logic [4:0]       s1_special_flags, flags;
  logic             carry, borrow, shl, ovf;
  logic             unused_lrs;
  assign unused_lrs = lrs_i[2];
  assign s2_adv = !s2_valid | out_ready_i;
  assign in_ready_o = !s1_valid | s2_adv;
  assign out_valid_o = s2_valid;
  // Decrement is an all-ones addend: a 25-bit two's-complement subtract of one ulp
  assign addend = round_i == RND_DEC ? '1 : round_i == RND_INC ? (SIG_W+1)'(1) : '0;
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv & s1_valid) begin
        result_o <= res;
        fflags_o <= flags;
      end
    end
  always_ff @(posedge clk_i)
    if (in_ready_o & in_valid_i) begin
      s1_sig <= {1'b0, sig_i} + addend;
      s1_msb <= sig_i[SIG_W-1];
      s1_exp <= exp_i;
      s1_sign <= sign_i;
      s1_rm <= rm_i;
      s1_nx <= lrs_i[1] | lrs_i[0];
      s1_special <= special_i;
      s1_special_res <= special_res_i;
      s1_special_flags <= special_flags_i;
    end
  fpu_overflow_select u_ovf (
    .rm  (s1_rm),
    .sign(s1_sign),
    .res (ovf_res)
  );
  always_comb begin
    carry = s1_sig[SIG_W];
    // Borrow: a normalized significand lost its hidden bit through the decrement
    borrow = !carry & !s1_sig[SIG_W-1] & s1_msb;
    shl = borrow & (s1_exp >= EXP_W'(2));
    n_sig = carry ? s1_sig[SIG_W:1] : shl ? {s1_sig[SIG_W-2:0], 1'b1} : s1_sig[SIG_W-1:0];
    n_exp = carry ? s1_exp + 1'b1 : shl ? s1_exp - 1'b1 : borrow ? '0 :
            ((s1_exp == '0) & s1_sig[SIG_W-1]) ? EXP_W'(1) : s1_exp;
    ovf = n_exp >= EXP_W'(255);
    flags = '0;
    flags[FLAG_NV] = 1'b0;
    flags[FLAG_DZ] = 1'b0;
    flags[FLAG_OF] = ovf;
    flags[FLAG_UF] = (n_exp == '0) & s1_nx;
    flags[FLAG_NX] = s1_nx | ovf;
    flags = s1_special ? s1_special_flags : flags;
    res = s1_special ? s1_special_res : ovf ? ovf_res : {s1_sign, n_exp[7:0], n_sig[SIG_W-2:0]};
  end
endmodule

// File: tb/tb_fpu_add_sub_round_apply.sv
// tb_fpu_add_sub_round_apply: directed and randomized checks of the round-apply stage against a value-level model
module tb_fpu_add_sub_round_apply;
  typedef struct packed {
    logic        s;
    logic [9:0]  e;
    logic [23:0] m;
    logic [2:0]  lrs;
    logic [1:0]  rnd;
    logic [2:0]  rm;
    logic        sp;
    logic [31:0] sres;
    logic [4:0]  sfl;
  } bundle_t;
  logic        clk_i = 1'b0;
  logic        reset_i, in_valid_i, in_ready_o, sign_i, special_i, out_valid_o, out_ready_i;
  logic [9:0]  exp_i;
  logic [23:0] sig_i;
  logic [2:0]  lrs_i, rm_i;
  logic [1:0]  round_i;
  logic [31:0] special_res_i, result_o;
  logic [4:0]  special_flags_i, fflags_o;
  int tests = 0;
  int fails = 0;
  logic [36:0] q[$];
  logic [36:0] nxt;
  logic        accepted = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_fl;
  fpu_add_sub_round_apply #(.EXP_W(10), .SIG_W(24)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .lrs_i(lrs_i), .round_i(round_i), .rm_i(rm_i),
    .special_i(special_i), .special_res_i(special_res_i), .special_flags_i(special_flags_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o), .fflags_o(fflags_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  function automatic logic [36:0] model(input bundle_t b);
    int s, e;
    logic nx, of, uf, to_inf;
    logic [31:0] r;
    if (b.sp) return {b.sres, b.sfl};
    s = int'(b.m) + (b.rnd == 2'b01 ? 1 : b.rnd == 2'b11 ? -1 : 0);
    e = int'(b.e);
    if (s >= (1 << 24)) begin
      s = s / 2;
      e = e + 1;
    end else if (s < (1 << 23) && int'(b.m) >= (1 << 23)) begin
      if (e >= 2) begin
        s = 2 * s + 1;
        e = e - 1;
      end else e = 0;
    end else if (e == 0 && s >= (1 << 23)) e = 1;
    nx = b.lrs[1] | b.lrs[0];
    of = e >= 255;
    uf = (e == 0) && nx;
    case (b.rm)
      3'd1: to_inf = 1'b0;
      3'd2: to_inf = b.s;
      3'd3: to_inf = !b.s;
      default: to_inf = 1'b1;
    endcase
    r = of ? {b.s, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF} : {b.s, e[7:0], s[22:0]};
    return {r, 2'b00, of, uf, nx | of};
  endfunction
  function automatic bundle_t mk(input logic s, input logic [9:0] e, input logic [23:0] m,
                                 input logic [2:0] lrs, input logic [1:0] rnd, input logic [2:0] rm);
    bundle_t b;
    b = '0;
    b.s = s; b.e = e; b.m = m; b.lrs = lrs; b.rnd = rnd; b.rm = rm;
    return b;
  endfunction
  function automatic bundle_t rnd_b();
    bundle_t b;
    b.s = 1'($urandom_range(0, 1));
    b.e = 10'($urandom_range(0, 260));
    b.m = (b.e == 0) ? 24'($urandom_range(1, 24'h7F_FFFF)) : {1'b1, 23'($urandom)};
    if (b.e != 0 && $urandom_range(0, 5) == 0) b.m = 24'hFF_FFFF;
    if (b.e != 0 && $urandom_range(0, 5) == 0) b.m = 24'h80_0000;
    b.lrs = 3'($urandom);
    b.rnd = 2'($urandom);
    b.rm = 3'($urandom_range(0, 7));
    b.sp = $urandom_range(0, 15) == 0;
    b.sres = $urandom;
    b.sfl = 5'($urandom);
    return b;
  endfunction
  task automatic put(input bundle_t b);
    sign_i = b.s; exp_i = b.e; sig_i = b.m; lrs_i = b.lrs; round_i = b.rnd; rm_i = b.rm;
    special_i = b.sp; special_res_i = b.sres; special_flags_i = b.sfl;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic tick();
    logic [36:0] w;
    #1;
    if (stalled) begin
      chk("hold_result", result_o, held_res);
      chk("hold_fflags", 32'(fflags_o), 32'(held_fl));
    end
    stalled = out_valid_o && !out_ready_i;
    held_res = result_o;
    held_fl = fflags_o;
    if (out_valid_o && out_ready_i) begin
      tests++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_output: observed %h/%h expected nothing pending", result_o, fflags_o);
      end
      if (q.size() > 0) begin
        w = q.pop_front();
        chk("result", result_o, w[36:5]);
        chk("fflags", 32'(fflags_o), 32'(w[4:0]));
      end
    end
    accepted = in_valid_i && in_ready_o;
    if (accepted) q.push_back(nxt);
    @(negedge clk_i);
  endtask
  task automatic send(input bundle_t b, input logic [36:0] want);
    int n;
    n = 0;
    put(b);
    nxt = want;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 20);
    in_valid_i = 1'b0;
    chk("accept", 32'(accepted), 32'd1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask
  initial begin
    bundle_t     dir_b[12];
    logic [36:0] dir_w[12];
    bundle_t     bp_b[4];
    bundle_t     cur;
    int lat, sent, c;
    reset_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    put('0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_result", result_o, 32'd0);
    chk("rst_fflags", 32'(fflags_o), 32'd0);
    send(mk(1'b0, 10'd127, 24'h80_0000, 3'b011, 2'b01, 3'd0), {32'h3F80_0001, 5'h01});
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      lat++;
      tick();
    end
    chk("latency", lat, 32'd2);
    drain();
    dir_b[0] = mk(1'b0, 10'd127, 24'hFF_FFFF, 3'b001, 2'b01, 3'd0);  dir_w[0] = {32'h4000_0000, 5'h01};
    dir_b[1] = mk(1'b0, 10'd128, 24'h80_0000, 3'b011, 2'b11, 3'd1);  dir_w[1] = {32'h3FFF_FFFF, 5'h01};
    dir_b[2] = mk(1'b0, 10'd1,   24'h80_0000, 3'b011, 2'b11, 3'd1);  dir_w[2] = {32'h007F_FFFF, 5'h03};
    dir_b[3] = mk(1'b0, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd0);  dir_w[3] = {32'h7F80_0000, 5'h05};
    dir_b[4] = mk(1'b1, 10'd255, 24'h80_0000, 3'b000, 2'b00, 3'd1);  dir_w[4] = {32'hFF7F_FFFF, 5'h05};
    dir_b[5] = mk(1'b0, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd2);  dir_w[5] = {32'h7F7F_FFFF, 5'h05};
    dir_b[6] = mk(1'b1, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd2);  dir_w[6] = {32'hFF80_0000, 5'h05};
    dir_b[7] = mk(1'b1, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd3);  dir_w[7] = {32'hFF7F_FFFF, 5'h05};
    dir_b[8] = mk(1'b0, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd3);  dir_w[8] = {32'h7F80_0000, 5'h05};
    dir_b[9] = mk(1'b1, 10'd254, 24'hFF_FFFF, 3'b000, 2'b01, 3'd4);  dir_w[9] = {32'hFF80_0000, 5'h05};
    dir_b[10] = mk(1'b0, 10'd300, 24'h80_0000, 3'b000, 2'b00, 3'd6); dir_w[10] = {32'h7F80_0000, 5'h05};
    dir_b[11] = mk(1'b0, 10'd0,  24'h7F_FFFF, 3'b010, 2'b01, 3'd0);  dir_w[11] = {32'h0080_0000, 5'h01};
    for (int i = 0; i < 12; i++) begin
      send(dir_b[i], dir_w[i]);
      drain();
    end
    for (int i = 0; i < 4; i++) bp_b[i] = rnd_b();
    sent = 0;
    c = 0;
    while ((sent < 4 || q.size() > 0) && c < 30) begin
      in_valid_i = sent < 4;
      if (sent < 4) begin
        put(bp_b[sent]);
        nxt = model(bp_b[sent]);
      end
      out_ready_i = !(c >= 3 && c <= 5);
      #1;
      if (c == 3) chk("in_ready_full_stall", 32'(in_ready_o), 32'd0);
      tick();
      if (accepted) sent++;
      c++;
    end
    chk("backpressure_sent", sent, 32'd4);
    drain();
    cur = '0;
    cur.sp = 1'b1;
    cur.sres = 32'h7FC0_0000;
    cur.sfl = 5'h10;
    send(cur, {32'h7FC0_0000, 5'h10});
    drain();
    send(cur, {32'h7FC0_0000, 5'h10});
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    q.delete();
    stalled = 1'b0;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_fflags", 32'(fflags_o), 32'd0);
    out_ready_i = 1'b1;
    repeat (5) tick();
    send(mk(1'b0, 10'd127, 24'h80_0000, 3'b011, 2'b01, 3'd0), {32'h3F80_0001, 5'h01});
    drain();
    sent = 0;
    cur = rnd_b();
    for (int k = 0; k < 4000 && (sent < 300 || q.size() > 0); k++) begin
      in_valid_i = sent < 300 && $urandom_range(0, 3) != 0;
      put(cur);
      nxt = model(cur);
      out_ready_i = $urandom_range(0, 3) != 0;
      tick();
      if (accepted) begin
        sent++;
        cur = rnd_b();
      end
    end
    chk("random_sent", sent, 32'd300);
    chk("random_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_add_sub_round_apply.md
# fpu_add_sub_round_apply

Pipelined stage directly downstream of the add/sub rounding-decision logic. It applies the 2-bit rounding increment/decrement to the normalized significand, renormalizes after carry-out or borrow, and resolves overflow per rounding mode. It packs the IEEE-754 single-precision result and raises fflags. Two registered stages with valid/ready flow control connect it to the FPU writeback mux.

## Interface
Parameters:
- EXP_W, 10, width of the unbiased-overflow-capable biased exponent input
- SIG_W, 24, significand width including the hidden bit

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-low reset
- in_valid_i  in  1  operand bundle valid
- in_ready_o  out  1  stage can accept the bundle
- sign_i  in  1  result sign
- exp_i  in  EXP_W  biased exponent after normalization; 0 means subnormal, ≥255 means overflow
- sig_i  in  SIG_W  normalized significand, truncated (hidden bit at MSB)
- lrs_i  in  3  {L,R,S} bits
- round_i  in  2  rounding decision: 00 none, 01 add 1 ulp, 11 subtract 1 ulp, 10 none
- rm_i  in  3  resolved rounding mode (000 RNE … 100 RMM)
- special_i  in  1  bypass: NaN/inf/exact-zero already resolved upstream
- special_res_i  in  32  bypass result
- special_flags_i  in  5  bypass flags
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- result_o  out  32  packed single-precision result
- fflags_o  out  5  {NV,DZ,OF,UF,NX}

## Operation
- Stage 1 (S1): sig_r = {1'b0,sig_i} + {SIG_W+1{round_i==11}} or +1 if round_i==01. This is a 25-bit two's-complement add. Also registers exp, sign, rm, inexact = lrs_i[1]|lrs_i[0], and the special fields.
- Stage 2 (S2): renormalize and pack.
  - Carry (sig_r[24]=1): shift right by 1 and increment exp. The dropped LSB is always 0 because the carry only occurs from all-ones.
  - Borrow (sig_r[23]=0, exp≥2, original sig_i[23]=1): shift left by 1, shift in 1, and decrement exp.
  - If exp is 1 on borrow: exp becomes 0 and the mantissa is not shifted (subnormal).
  - Subnormal promotion: exp=0 and sig_r[23]=1 after increment → exp=1.
- Overflow: final exp ≥ 255 → OF=1, NX=1. Result depends on rm_i:
  - RNE/RMM: ±inf.
  - RTZ: ±0x7F7FFFFF.
  - RDN: −inf if sign else +max.
  - RUP: +inf if !sign else −max.
  - Invalid rm: ±inf.
- Normal pack: {sign, exp[7:0], sig[22:0]}.
- Flags:
  - NX = inexact | OF.
  - UF = (final exp==0) & inexact.
  - NV = DZ = 0.
- Special: result_o = special_res_i and fflags_o = special_flags_i. Rounding is ignored.

## Timing
- Latency: 2 cycles from the accept edge (in_valid_i & in_ready_o) to out_valid_o, with no stalls. Throughput is 1 per cycle.
- Each stage holds a valid bit.
  - S2 advances when !s2_valid | out_ready_i.
  - S1 advances when S2 advances or !s2_valid.
  - in_ready_o = !s1_valid | S1 advances. It is combinational; there is no skid buffer.
- While out_valid_o=1 and out_ready_i=0: result_o and fflags_o hold stable, and in_ready_o drops once S1 is full.
- Simultaneous accept and drain with both stages full: all data shifts by one, with no bubble and no loss.
- Reset (reset_i=0 at a clock edge): both valid bits clear. result_o=0, fflags_o=0, out_valid_o=0, in_ready_o=1 in the following cycle. In-flight bundles are discarded. Data registers may reset to 0.
- Data registers load only on stage advance, so there is no X-propagation when idle.

## Structure
- Shared fpu package holds:
  - rounding-mode constants (RM_RNE..RM_RMM)
  - round_i encodings (RND_NONE, RND_INC, RND_DEC)
  - fflags bit indices
  - constants F32_PINF = 0x7F800000 and F32_MAX = 0x7F7FFFFF
- One sub-module: fpu_overflow_select. It is combinational and maps (rm, sign) to the saturated or infinite result.

## Test plan
- sign 0, exp 127, sig 0x800000, round 01, lrs 011, RNE → 0x3F800001, fflags 0x01, out_valid 2 cycles after accept.
- exp 127, sig 0xFFFFFF, round 01 → carry renormalize → 0x40000000, NX.
- sign 0, exp 128, sig 0x800000, round 11, RTZ → borrow → 0x3FFFFFFF, NX. Also exp 1, same sig, round 11 → 0x007FFFFF, fflags UF|NX = 0x03.
- exp 254, sig 0xFFFFFF, round 01: RNE → 0x7F800000, fflags 0x05. Repeat with sign 1, RTZ via exp 255 input → 0xFF7FFFFF, 0x05.
- Back-to-back 4 bundles with out_ready_i low for cycles 3–5 → in_ready_o low once both stages full; results emerge in order, none duplicated or lost.
- Special bypass of NaN 0x7FC00000 with flags 0x10; then reset_i asserted mid-flight → out_valid_o=0 next cycle, the in-flight bundle is never emitted, and subsequent input is processed normally.
